// File: rtl/conf_int_dot_seq.sv
// Sequential integer dot-product controller driving an external combinational MAC.
// Approximate mode zeroes the low Pn operand bits before they reach the MAC.
module conf_int_dot_seq #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int Pn                 = 8,
    parameter int LEN_W              = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    input  logic                          apx_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
    input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_data,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state, state_nx;
    logic [DATA_PATH_BITWIDTH-1:0] acc, op_a, op_b, low_mask;
    logic                          op_valid;
    logic [LEN_W-1:0]              cnt, len_q;
    logic                          apx_q;
    logic                          accept, last_beat;

    // Built bitwise so that Pn == DATA_PATH_BITWIDTH needs no special case.
    always_comb begin
        low_mask = '0;
        for (int unsigned i = 0; i < DATA_PATH_BITWIDTH; i++)
            low_mask[i] = (i < unsigned'(Pn));
    end

    assign accept    = in_valid && (state == RUN);
    assign last_beat = accept && (cnt == len_q - LEN_W'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
            RUN:     if (last_beat) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            len_q    <= '0;
            apx_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            op_valid <= accept;
            if (accept) begin
                op_a <= apx_q ? (in_a & ~low_mask) : in_a;
                op_b <= apx_q ? (in_b & ~low_mask) : in_b;
                cnt  <= cnt + LEN_W'(1);
            end
            if (state == IDLE && start) begin
                len_q <= len;
                apx_q <= apx_mode;
                acc   <= '0;
                cnt   <= '0;
            end else if (op_valid) begin
                acc <= mac_d;
            end
        end
    end

    // Outputs are gated by rst so they read zero throughout reset, even before the first edge.
    assign in_ready  = rst && (state == RUN);
    assign out_valid = rst && (state == DONE);
    assign busy      = rst && (state != IDLE);
    assign out_data  = rst ? acc : '0;
    assign mac_c     = rst ? acc : '0;
    assign mac_a     = op_a;
    assign mac_b     = op_b;

endmodule

// File: doc/conf_int_dot_seq.md
CONF_INT_DOT_SEQ -- requirements
Module: conf_int_dot_seq

Interface
REQ-001 SHALL have parameter DATA_PATH_BITWIDTH, default 32, as the operand, accumulator and result width.
REQ-002 SHALL have parameter Pn, default 8, as the number of low operand bits zeroed in approximate mode.
REQ-003 SHALL have parameter LEN_W, default 8, as the vector-length field width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-007 SHALL have port len, input, LEN_W bits: number of operand pairs in the job, latched with start.
REQ-008 SHALL have port apx_mode, input, 1 bit: 1 selects truncated operands; latched with start.
REQ-009 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts an operand pair.
REQ-011 SHALL have ports in_a and in_b, inputs, DATA_PATH_BITWIDTH bits each: operand pair.
REQ-012 SHALL have ports mac_a, mac_b and mac_c, outputs, DATA_PATH_BITWIDTH bits each: operands driven to the downstream combinational MAC.
REQ-013 SHALL have port mac_d, input, DATA_PATH_BITWIDTH bits: MAC result, mac_a*mac_b+mac_c modulo 2^DATA_PATH_BITWIDTH, same cycle.
REQ-014 SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 SHALL have port out_data, output, DATA_PATH_BITWIDTH bits: dot-product result.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE, start=1, len>0: SHALL latch len and apx_mode, clear acc and cnt, and go to RUN.
REQ-020 IDLE, start=1, len=0: SHALL clear acc and go directly to DONE; the result is 0.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 in_ready SHALL equal 1 only in RUN; a beat is accepted when in_valid=1 and in_ready=1.
REQ-023 On an accepted beat, the block SHALL register op_a and op_b as in_a and in_b.
REQ-024 On an accepted beat, when apx_mode is latched as 1, the block SHALL force op_a[Pn-1:0] and op_b[Pn-1:0] to 0.
REQ-025 On an accepted beat, the block SHALL set op_valid=1; op_valid SHALL be 0 in any cycle without an accepted beat.
REQ-026 mac_a and mac_b SHALL be driven by op_a and op_b; mac_c SHALL be driven by acc.
REQ-027 The cycle after op_valid=1, the block SHALL load mac_d into acc; acc SHALL hold when op_valid=0.
REQ-028 Back-to-back beats SHALL each see the acc value updated by the previous beat, with no bubble required.
REQ-029 cnt SHALL increment per accepted beat; when the accepted beat has cnt==len-1, the FSM SHALL go to DRAIN.
REQ-030 DRAIN SHALL last exactly 1 cycle, in which the last op_valid retires into acc, then go to DONE.
REQ-031 DONE SHALL drive out_valid=1 and out_data=acc, both held stable until out_ready=1.
REQ-032 When out_valid=1 and out_ready=1, the FSM SHALL return to IDLE; start in that same cycle SHALL be ignored.
REQ-033 Latency SHALL be: out_valid rises 2 cycles after the last beat is accepted, or 1 cycle after start when len=0.
REQ-034 Arithmetic SHALL wrap modulo 2^DATA_PATH_BITWIDTH, with no saturation or overflow flag.
REQ-035 In_valid gaps in RUN SHALL stall the job indefinitely, with state and acc preserved.

Reset
REQ-036 rst=0 at a clock edge SHALL force IDLE and clear acc, cnt, op_a, op_b, op_valid, the latched len and the latched apx_mode.
REQ-037 While rst=0, in_ready, out_valid and busy SHALL be 0, and out_data and mac_c SHALL be 0.
REQ-038 Reset in any state, including mid-job, SHALL abandon the job; the first start after release SHALL begin a fresh job.

Verification
REQ-039 Bench SHALL cover: len=3, apx_mode=0, pairs (2,3),(4,5),(6,7), out_ready=1 -> out_data=68, out_valid 2 cycles after the third accept.
REQ-040 Bench SHALL cover: len=2, apx_mode=1, Pn=8, pairs (0x1FF,0x102),(0xFF,0x10) -> operands masked to 0x100,0x100 and 0x0,0x0, out_data=0x10000.
REQ-041 Bench SHALL cover: len=0 -> out_valid one cycle after start, out_data=0, in_ready never asserted.
REQ-042 Bench SHALL cover: len=2, out_ready held low 5 cycles in DONE -> out_data stable, start pulses ignored, IDLE after the handshake.
REQ-043 Bench SHALL cover: len=4, rst=0 after 2 beats -> in_ready=0, busy=0, acc=0; new job len=1 pair (3,3) -> out_data=9.
REQ-044 Bench SHALL cover: len=2, pairs (0xFFFFFFFF,2),(1,1) -> out_data=0xFFFFFFFF (wrap), with in_valid gaps of 3 cycles between beats not changing the result.
